// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit.
// S1 holds the operands; S2 holds the result and its zero/parity flags.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic             Z,
    output logic             P,
    output logic [CNT_W-1:0] CNT
);

    logic             s1_v_q;
    logic             s1_v_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;

    logic             s2_v_q;
    logic             s2_v_d;
    logic [WIDTH-1:0] q_q;
    logic             z_q;
    logic             p_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             in_xfer;
    logic             out_xfer;
    logic             s1_adv;
    logic [WIDTH-1:0] res;

    // S1 may advance whenever S2 is free or being drained this cycle.
    assign out_xfer = s2_v_q & out_ready;
    assign s1_adv   = s1_v_q & (~s2_v_q | out_ready);
    assign in_ready = ~s1_v_q | ~s2_v_q | out_ready;
    assign in_xfer  = in_valid & in_ready;

    assign s1_v_d = in_xfer | (s1_v_q & ~s1_adv);
    assign s2_v_d = s1_adv | (s2_v_q & ~out_xfer);
    assign cnt_d  = out_xfer ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        res = '0;
        unique case (op_q)
            3'b000: res = ~(a_q & b_q);
            3'b001: res = a_q & b_q;
            3'b010: res = a_q | b_q;
            3'b011: res = ~(a_q | b_q);
            3'b100: res = a_q ^ b_q;
            3'b101: res = ~(a_q ^ b_q);
            3'b110: res = ~a_q;
            3'b111: res = a_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            s2_v_q <= 1'b0;
            q_q    <= '0;
            z_q    <= 1'b1;
            p_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            cnt_q  <= cnt_d;
            if (in_xfer) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= OP;
            end
            if (s1_adv) begin
                q_q <= res;
                z_q <= ~|res;
                p_q <= ^res;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign Q         = q_q;
    assign Z         = z_q;
    assign P         = p_q;
    assign CNT       = cnt_q;

endmodule
